adf4351_spi_rx: RTL

Synthesizable receiver for the ADF4351 three-wire programming interface (CLK, DATA, LE). It sits on the pins driven by the PLL programming master. It oversamples the serial lines with the system clock and reassembles each 32-bit word. It decodes the control bits [2:0] into R0..R5 and keeps a shadow register file for loopback checking and on-board self-test of the programming path.

---
 rtl/adf4351_spi_rx_pkg.sv | 28 ++
 rtl/adf4351_spi_rx_sync_edge.sv | 44 ++++
 rtl/adf4351_spi_rx.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/adf4351_spi_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adf4351_defs (package)
// Description : Shared constants, FSM encoding and helpers for the ADF4351
//               three-wire programming receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package adf4351_defs;

    localparam int unsigned ADF_WORD_BITS = 32;
    localparam int unsigned ADF_NUM_REGS  = 6;
    localparam int unsigned ADF_CTRL_MSB  = 2;
    localparam int unsigned ADF_CTRL_LSB  = 0;
    localparam int unsigned ADF_CNT_BITS  = 6;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } adf_state_e;

    // Control bits select R0..R5; codes 6 and 7 do not exist on the part.
    function automatic logic adf_addr_ok(input logic [2:0] addr);
        return addr <= 3'(ADF_NUM_REGS - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/adf4351_spi_rx_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge
// Description : Multi-flop synchronizer with history flop and registered
//               rise/fall strobes for one asynchronous serial pin.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   rise_q;
    logic                   fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            hist_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
            fall_q <= ~sync_q[SYNC_STAGES-1] & hist_q;
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

`default_nettype wire

// File: rtl/adf4351_spi_rx.sv
`default_nettype none
// ============================================================================
// Module      : adf4351_spi_rx
// Description : ADF4351 CLK/DATA/LE receiver: frames 32-bit words, decodes
//               R0..R5 and keeps a readable shadow register file.
// Revision    : 1.0 - initial release
// ============================================================================
module adf4351_spi_rx
    import adf4351_defs::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_clk,
    input  logic        spi_data,
    input  logic        spi_le,
    output logic        word_valid,
    output logic [31:0] word,
    output logic [2:0]  reg_addr,
    output logic        frame_err,
    output logic        err_len,
    output logic        err_addr,
    output logic [5:0]  loaded_mask,
    input  logic [2:0]  rd_sel,
    output logic [31:0] rd_data
);

    logic                    clk_rise;
    logic                    le_rise;
    logic                    le_fall;
    logic                    data_lvl;
    logic [1:0]              clk_sync_unused;
    logic [1:0]              data_edges_unused;

    adf_state_e              state_q, state_d;
    logic [31:0]             shreg_q, shreg_d;
    logic [ADF_CNT_BITS-1:0] cnt_q, cnt_d;
    logic [31:0]             word_q, word_d;
    logic [2:0]              addr_q, addr_d;
    logic [5:0]              mask_q, mask_d;
    logic                    err_len_q, err_len_d;
    logic                    err_addr_q, err_addr_d;
    logic                    valid_q, valid_d;
    logic                    ferr_q, ferr_d;
    logic                    wr_en;
    logic [31:0]             shadow_q [ADF_NUM_REGS];

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (spi_clk),
        .level_o (clk_sync_unused[0]),
        .rise_o  (clk_rise),
        .fall_o  (clk_sync_unused[1])
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (spi_data),
        .level_o (data_lvl),
        .rise_o  (data_edges_unused[0]),
        .fall_o  (data_edges_unused[1])
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_le (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (spi_le),
        .level_o (),
        .rise_o  (le_rise),
        .fall_o  (le_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            mask_q     <= '0;
            err_len_q  <= 1'b0;
            err_addr_q <= 1'b0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            mask_q     <= mask_d;
            err_len_q  <= err_len_d;
            err_addr_q <= err_addr_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        addr_d     = addr_q;
        mask_d     = mask_q;
        err_len_d  = err_len_q;
        err_addr_d = err_addr_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                // A CLK rise landing with the LE fall is deliberately lost.
                if (le_fall) begin
                    state_d = SHIFT;
                    shreg_d = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (clk_rise) begin
                    shreg_d = {shreg_q[30:0], data_lvl};
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                // Evaluated on the post-shift values so a coincident last bit counts.
                if (le_rise) begin
                    state_d = IDLE;
                    if (cnt_d != ADF_CNT_BITS'(ADF_WORD_BITS)) begin
                        ferr_d    = 1'b1;
                        err_len_d = 1'b1;
                    end else if (!adf_addr_ok(shreg_d[ADF_CTRL_MSB:ADF_CTRL_LSB])) begin
                        ferr_d     = 1'b1;
                        err_addr_d = 1'b1;
                    end else begin
                        valid_d = 1'b1;
                        wr_en   = 1'b1;
                        word_d  = shreg_d;
                        addr_d  = shreg_d[ADF_CTRL_MSB:ADF_CTRL_LSB];
                        mask_d[shreg_d[ADF_CTRL_MSB:ADF_CTRL_LSB]] = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar g = 0; g < ADF_NUM_REGS; g++) begin : g_shadow
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shadow_q[g] <= '0;
            end else if (wr_en && (addr_d == 3'(g))) begin
                shadow_q[g] <= word_d;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_sel < 3'(ADF_NUM_REGS)) begin
            rd_data = shadow_q[rd_sel];
        end
    end

    assign word_valid  = valid_q;
    assign word        = word_q;
    assign reg_addr    = addr_q;
    assign frame_err   = ferr_q;
    assign err_len     = err_len_q;
    assign err_addr    = err_addr_q;
    assign loaded_mask = mask_q;

endmodule

`default_nettype wire
